store_queue: RTL and testbench

- Parametrised, age-ordered store queue; successor to the fixed 4-entry store buffer inside the memory functional unit.
- Holds dispatched stores/outputs in program order and snoops the CDB for store data.
- Accepts resolved addresses, marks entries committed or invalidated by the ROB, and drains committed stores to the memory port one per cycle.
- Answers combinational load queries with youngest-match forwarding or a stall; supports full flush of uncommitted entries on mispredict.

---
 rtl/fcpu_pkg.sv | 32 +++
 rtl/sq_age_match.sv | 32 +++
 rtl/store_queue.sv | 204 ++++++++++++++++++++
 tb/tb_store_queue.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcpu_pkg.sv
// Shared CPU definitions: default datapath widths, the store-queue entry
// layout and opcode-class helpers.
package fcpu_pkg;

  localparam int unsigned FCPU_DATA_W = 32;
  localparam int unsigned FCPU_ID_W   = 6;
  localparam int unsigned FCPU_OP_W   = 6;

  // One store-queue slot at the default widths.
  typedef struct packed {
    logic                   valid;
    logic [FCPU_ID_W-1:0]   id;
    logic [FCPU_OP_W-1:0]   opcode;
    logic [FCPU_DATA_W-1:0] addr;
    logic                   addr_ready;
    logic [FCPU_DATA_W-1:0] data;
    logic [FCPU_ID_W-1:0]   data_id;
    logic                   data_ready;
    logic                   committed;
    logic                   invalidate;
  } sq_entry_t;

  // Memory opcodes are grouped by their top three bits.
  function automatic logic is_store(input logic [FCPU_OP_W-1:0] op);
    return op[FCPU_OP_W-1 -: 3] == 3'b100;
  endfunction

  function automatic logic is_load(input logic [FCPU_OP_W-1:0] op);
    return op[FCPU_OP_W-1 -: 3] == 3'b011;
  endfunction

endpackage

// File: rtl/sq_age_match.sv
// Youngest-match picker for a circular queue whose live entries run
// contiguously from head.
// Ports: valid/match per slot, head slot index; onehot youngest hit, hit flag.
module sq_age_match #(
  parameter int unsigned DEPTH_W = 3
) (
  input  logic [2**DEPTH_W-1:0] valid,
  input  logic [2**DEPTH_W-1:0] match,
  input  logic [DEPTH_W-1:0]    head,
  output logic [2**DEPTH_W-1:0] onehot,
  output logic                  hit
);
  localparam int unsigned DEPTH = 2**DEPTH_W;

  logic [DEPTH_W-1:0] idx;

  // Walk oldest to youngest; the last hit seen is the youngest.
  always_comb begin
    onehot = '0;
    hit    = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + DEPTH_W'(k);
      if (valid[idx] && match[idx]) begin
        onehot      = '0;
        onehot[idx] = 1'b1;
        hit         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/store_queue.sv
// Age-ordered store queue: holds dispatched stores in program order, snoops
// the CDB for data, takes resolved addresses, marks ROB commits, drains
// committed stores one per cycle and answers load forwarding queries.
// Ports: alloc_* (dispatch), addr_* (AGU), cdb_valid/cdb, commit_* (ROB),
// flush, ld_* (load query, combinational), mem_* (drain port), count/empty.
// Optional macro STORE_QUEUE_FORWARD_EN enables store-to-load forwarding;
// without it any address match or unresolved address stalls the load.
module store_queue
  import fcpu_pkg::*;
#(
  parameter int unsigned DEPTH_W = 3,
  parameter int unsigned DATA_W  = FCPU_DATA_W,
  parameter int unsigned ID_W    = FCPU_ID_W,
  parameter int unsigned OP_W    = FCPU_OP_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic [ID_W-1:0]        alloc_id,
  input  logic [OP_W-1:0]        alloc_opcode,
  input  logic [DATA_W-1:0]      alloc_data,
  input  logic [ID_W-1:0]        alloc_data_id,
  input  logic                   alloc_data_filled,
  input  logic                   addr_valid,
  input  logic [ID_W-1:0]        addr_id,
  input  logic [DATA_W-1:0]      addr_value,
  input  logic                   cdb_valid,
  input  logic [ID_W+DATA_W-1:0] cdb,
  input  logic                   commit_valid,
  input  logic                   commit_invalidate,
  input  logic [ID_W-1:0]        commit_id,
  input  logic                   flush,
  input  logic                   ld_valid,
  input  logic [DATA_W-1:0]      ld_addr,
  output logic                   ld_forward,
  output logic [DATA_W-1:0]      ld_data,
  output logic                   ld_stall,
  output logic                   mem_valid,
  output logic [OP_W-1:0]        mem_opcode,
  output logic [ID_W-1:0]        mem_id,
  output logic [DATA_W-1:0]      mem_address,
  output logic [DATA_W-1:0]      mem_data,
  input  logic                   mem_ready,
  output logic [DEPTH_W:0]       count,
  output logic                   empty
);
  localparam int unsigned DEPTH = 2**DEPTH_W;
  localparam int unsigned PTR_W = DEPTH_W + 1;

  logic [PTR_W-1:0]   head, tail;
  logic [DEPTH_W-1:0] head_idx, tail_idx;

  logic [DEPTH-1:0]   e_valid, e_addr_ready, e_data_ready, e_committed, e_inval;
  logic [ID_W-1:0]    e_id      [DEPTH];
  logic [ID_W-1:0]    e_data_id [DEPTH];
  logic [OP_W-1:0]    e_opcode  [DEPTH];
  logic [DATA_W-1:0]  e_addr    [DEPTH];
  logic [DATA_W-1:0]  e_data    [DEPTH];

  logic [ID_W-1:0]    cdb_tag;
  logic [DATA_W-1:0]  cdb_data;
  logic               full, do_alloc, alloc_cdb_hit, head_ok, silent_pop, pop;
  logic [DEPTH-1:0]   commit_hit, ld_match;
  logic [PTR_W-1:0]   ncommit;
  logic               unresolved;

  assign cdb_tag  = cdb[ID_W+DATA_W-1:DATA_W];
  assign cdb_data = cdb[DATA_W-1:0];
  assign head_idx = head[DEPTH_W-1:0];
  assign tail_idx = tail[DEPTH_W-1:0];

  // Occupancy from registered pointers only; a same-cycle drain does not free a slot.
  assign full        = (head_idx == tail_idx) && (head[DEPTH_W] != tail[DEPTH_W]);
  assign alloc_ready = !full && !flush;
  assign do_alloc    = alloc_valid && alloc_ready;
  assign count       = tail - head;
  assign empty       = (count == '0);

  assign alloc_cdb_hit = !alloc_data_filled && cdb_valid && (cdb_tag == alloc_data_id);

  // Drain control: invalidated commits leave silently, others wait for memory.
  assign head_ok    = e_valid[head_idx] && e_committed[head_idx];
  assign mem_valid  = head_ok && !e_inval[head_idx] && e_addr_ready[head_idx]
                      && e_data_ready[head_idx];
  assign silent_pop = head_ok && e_inval[head_idx];
  assign pop        = (mem_valid && mem_ready) || silent_pop;

  assign mem_opcode  = e_valid[head_idx] ? e_opcode[head_idx] : '0;
  assign mem_id      = e_valid[head_idx] ? e_id[head_idx]     : '0;
  assign mem_address = e_valid[head_idx] ? e_addr[head_idx]   : '0;
  assign mem_data    = e_valid[head_idx] ? e_data[head_idx]   : '0;

  // Per-slot commit/load matches and committed-entry count (flush survivors).
  always_comb begin
    commit_hit = '0;
    ld_match   = '0;
    ncommit    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      commit_hit[i] = commit_valid && e_valid[i] && (e_id[i] == commit_id);
      ld_match[i]   = !e_inval[i] && e_addr_ready[i] && (e_addr[i] == ld_addr);
      ncommit       = ncommit + PTR_W'(e_valid[i] && (e_committed[i] || commit_hit[i]));
    end
  end

  assign unresolved = |(e_valid & ~e_inval & ~e_addr_ready);

`ifdef STORE_QUEUE_FORWARD_EN
  logic [DEPTH-1:0]  ld_sel;
  logic              ld_hit;
  logic [DATA_W-1:0] sel_data;

  sq_age_match #(.DEPTH_W(DEPTH_W)) u_age_match (
    .valid  (e_valid),
    .match  (ld_match),
    .head   (head_idx),
    .onehot (ld_sel),
    .hit    (ld_hit)
  );

  // One-hot mux of the youngest matching entry's data.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      sel_data = sel_data | (e_data[i] & {DATA_W{ld_sel[i]}});
  end

  always_comb begin
    ld_forward = 1'b0;
    ld_stall   = 1'b0;
    ld_data    = '0;
    if (ld_valid) begin
      if (unresolved) begin
        ld_stall = 1'b1;
      end else if (ld_hit) begin
        if (|(ld_sel & e_data_ready)) begin
          ld_forward = 1'b1;
          ld_data    = sel_data;
        end else begin
          ld_stall = 1'b1;
        end
      end
    end
  end
`else
  assign ld_forward = 1'b0;
  assign ld_data    = '0;
  assign ld_stall   = ld_valid && (unresolved || |(e_valid & ld_match));
`endif

  // Pointer and entry state; later assignments in the slot loop take priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      e_valid      <= '0;
      e_addr_ready <= '0;
      e_data_ready <= '0;
      e_committed  <= '0;
      e_inval      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        e_id[i]      <= '0;
        e_data_id[i] <= '0;
        e_opcode[i]  <= '0;
        e_addr[i]    <= '0;
        e_data[i]    <= '0;
      end
    end else begin
      head <= head + PTR_W'(pop);
      tail <= flush ? (head + ncommit) : (tail + PTR_W'(do_alloc));
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (e_valid[i] && !e_data_ready[i] && cdb_valid && (e_data_id[i] == cdb_tag)) begin
          e_data[i]       <= cdb_data;
          e_data_ready[i] <= 1'b1;
        end
        if (e_valid[i] && addr_valid && (e_id[i] == addr_id)) begin
          e_addr[i]       <= addr_value;
          e_addr_ready[i] <= 1'b1;
        end
        if (commit_hit[i]) begin
          e_committed[i] <= 1'b1;
          e_inval[i]     <= commit_invalidate;
        end
        if (pop && (DEPTH_W'(i) == head_idx))
          e_valid[i] <= 1'b0;
        if (flush && e_valid[i] && !e_committed[i] && !commit_hit[i])
          e_valid[i] <= 1'b0;
        if (do_alloc && (DEPTH_W'(i) == tail_idx)) begin
          e_valid[i]      <= 1'b1;
          e_id[i]         <= alloc_id;
          e_opcode[i]     <= alloc_opcode;
          e_addr[i]       <= '0;
          e_addr_ready[i] <= 1'b0;
          e_data[i]       <= alloc_cdb_hit ? cdb_data : alloc_data;
          e_data_id[i]    <= alloc_data_id;
          e_data_ready[i] <= alloc_data_filled || alloc_cdb_hit;
          e_committed[i]  <= 1'b0;
          e_inval[i]      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_store_queue.sv
module tb_store_queue;
  localparam int DW = 32;
  localparam int IW = 6;
  localparam int OW = 6;
  localparam int DWID = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid, alloc_ready, alloc_data_filled;
  logic [IW-1:0] alloc_id, alloc_data_id;
  logic [OW-1:0] alloc_opcode;
  logic [DW-1:0] alloc_data;
  logic          addr_valid;
  logic [IW-1:0] addr_id;
  logic [DW-1:0] addr_value;
  logic          cdb_valid;
  logic [IW+DW-1:0] cdb;
  logic          commit_valid, commit_invalidate;
  logic [IW-1:0] commit_id;
  logic          flush;
  logic          ld_valid, ld_forward, ld_stall;
  logic [DW-1:0] ld_addr, ld_data;
  logic          mem_valid, mem_ready;
  logic [OW-1:0] mem_opcode;
  logic [IW-1:0] mem_id;
  logic [DW-1:0] mem_address, mem_data;
  logic [DWID:0] count;
  logic          empty;

  store_queue #(.DEPTH_W(DWID), .DATA_W(DW), .ID_W(IW), .OP_W(OW)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .alloc_opcode(alloc_opcode), .alloc_data(alloc_data), .alloc_data_id(alloc_data_id),
    .alloc_data_filled(alloc_data_filled),
    .addr_valid(addr_valid), .addr_id(addr_id), .addr_value(addr_value),
    .cdb_valid(cdb_valid), .cdb(cdb),
    .commit_valid(commit_valid), .commit_invalidate(commit_invalidate), .commit_id(commit_id),
    .flush(flush),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_forward(ld_forward), .ld_data(ld_data),
    .ld_stall(ld_stall),
    .mem_valid(mem_valid), .mem_opcode(mem_opcode), .mem_id(mem_id),
    .mem_address(mem_address), .mem_data(mem_data), .mem_ready(mem_ready),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboards: {opcode,id,addr,data} for drains, {fwd,stall,data} for loads.
  logic [OW+IW+DW+DW-1:0] mem_q[$];
  logic [DW+1:0]          ld_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drain monitor: every accepted memory transfer must match the next expected store.
  always @(negedge clk) begin
    if (mem_valid === 1'b1 && mem_ready === 1'b1) begin
      checks++;
      if (mem_q.size() == 0) begin
        errors++;
        $display("FAIL mem_unexpected: got id 0x%0h expected no transfer", mem_id);
      end else begin
        logic [OW+IW+DW+DW-1:0] e;
        e = mem_q.pop_front();
        if ({mem_opcode, mem_id, mem_address, mem_data} !== e) begin
          errors++;
          $display("FAIL mem_xfer: got 0x%0h expected 0x%0h",
                   {mem_opcode, mem_id, mem_address, mem_data}, e);
        end
      end
    end
  end

  // Load monitor: compares the combinational answer during each query cycle.
  always @(negedge clk) begin
    if (ld_valid === 1'b1) begin
      checks++;
      if (ld_q.size() == 0) begin
        errors++;
        $display("FAIL ld_unexpected: got query expected none");
      end else begin
        logic [DW+1:0] e;
        e = ld_q.pop_front();
        if ({ld_forward, ld_stall, ld_data} !== e) begin
          errors++;
          $display("FAIL ld_resp: got fwd=%0b stall=%0b data=0x%0h expected fwd=%0b stall=%0b data=0x%0h",
                   ld_forward, ld_stall, ld_data, e[DW+1], e[DW], e[DW-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [IW-1:0] id, input logic [OW-1:0] op, input logic [DW-1:0] d,
                          input logic [IW-1:0] did, input logic filled);
    alloc_valid = 1'b1; alloc_id = id; alloc_opcode = op; alloc_data = d;
    alloc_data_id = did; alloc_data_filled = filled;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic do_addr(input logic [IW-1:0] id, input logic [DW-1:0] a);
    addr_valid = 1'b1; addr_id = id; addr_value = a;
    tick();
    addr_valid = 1'b0;
  endtask

  task automatic do_commit(input logic [IW-1:0] id, input logic inv);
    commit_valid = 1'b1; commit_id = id; commit_invalidate = inv;
    tick();
    commit_valid = 1'b0; commit_invalidate = 1'b0;
  endtask

  task automatic do_cdb(input logic [IW-1:0] tag, input logic [DW-1:0] d);
    cdb_valid = 1'b1; cdb = {tag, d};
    tick();
    cdb_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic drain_one(input logic [OW-1:0] op, input logic [IW-1:0] id,
                           input logic [DW-1:0] a, input logic [DW-1:0] d);
    mem_q.push_back({op, id, a, d});
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  // fwd_* is the forwarding-build answer, nf_* the answer without forwarding.
  task automatic ld_query(input logic [DW-1:0] a, input logic fwd_f, input logic fwd_s,
                          input logic [DW-1:0] fwd_d, input logic nf_s);
`ifdef STORE_QUEUE_FORWARD_EN
    ld_q.push_back({fwd_f, fwd_s, fwd_d});
`else
    ld_q.push_back({1'b0, nf_s, {DW{1'b0}}});
`endif
    ld_valid = 1'b1; ld_addr = a;
    tick();
    ld_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_id = '0; alloc_opcode = '0; alloc_data = '0;
    alloc_data_id = '0; alloc_data_filled = 1'b0;
    addr_valid = 1'b0; addr_id = '0; addr_value = '0;
    cdb_valid = 1'b0; cdb = '0;
    commit_valid = 1'b0; commit_invalidate = 1'b0; commit_id = '0;
    flush = 1'b0; ld_valid = 1'b0; ld_addr = '0; mem_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_ld_forward", 64'(ld_forward), 64'd0);
    check("rst_ld_stall", 64'(ld_stall), 64'd0);
    check("rst_ld_data", 64'(ld_data), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_mem_bus", 64'({mem_opcode, mem_id, mem_address, mem_data} != '0), 64'd0);

    // Fill to capacity; the 9th alloc and a same-cycle alloc during drain are refused
    for (int i = 0; i < 8; i++)
      do_alloc(IW'(10 + i), 6'h20, DW'(32'h1000 + i), '0, 1'b1);
    check("full_count", 64'(count), 64'd8);
    check("full_alloc_ready", 64'(alloc_ready), 64'd0);
    check("full_empty", 64'(empty), 64'd0);
    do_alloc(6'd18, 6'h20, 32'hDEAD, '0, 1'b1);
    check("full_ignored_count", 64'(count), 64'd8);
    do_addr(6'd10, 32'h200);
    do_commit(6'd10, 1'b0);
    check("full_head_mem_valid", 64'(mem_valid), 64'd1);
    alloc_valid = 1'b1; alloc_id = 6'd18; alloc_data_filled = 1'b1;
    drain_one(6'h20, 6'd10, 32'h200, 32'h1000);
    alloc_valid = 1'b0;
    check("after_pop_count", 64'(count), 64'd7);
    check("after_pop_alloc_ready", 64'(alloc_ready), 64'd1);
    flush = 1'b1;
    #1;
    check("flush_blocks_alloc", 64'(alloc_ready), 64'd0);
    tick();
    flush = 1'b0;
    check("flush_all_count", 64'(count), 64'd0);

    // CDB snoop, address resolve, commit, drain
    do_alloc(6'd5, 6'h21, '0, 6'd9, 1'b0);
    do_cdb(6'd9, 32'hAB);
    do_addr(6'd5, 32'h100);
    check("uncommitted_mem_valid", 64'(mem_valid), 64'd0);
    do_commit(6'd5, 1'b0);
    check("committed_mem_valid", 64'(mem_valid), 64'd1);
    drain_one(6'h21, 6'd5, 32'h100, 32'hAB);
    check("drained_empty", 64'(empty), 64'd1);

    // Youngest-match forwarding
    do_alloc(6'd20, 6'h20, 32'd1, '0, 1'b1);
    do_alloc(6'd21, 6'h20, 32'd2, '0, 1'b1);
    do_addr(6'd20, 32'h40);
    do_addr(6'd21, 32'h40);
    ld_query(32'h40, 1'b1, 1'b0, 32'd2, 1'b1);
    ld_query(32'h44, 1'b0, 1'b0, 32'd0, 1'b0);
    ld_addr = 32'h40;
    #1;
    check("ld_idle_stall", 64'(ld_stall), 64'd0);
    check("ld_idle_forward", 64'(ld_forward), 64'd0);
    do_flush();

    // Unresolved address stalls every load
    do_alloc(6'd30, 6'h20, 32'h30, '0, 1'b1);
    ld_query(32'h80, 1'b0, 1'b1, 32'd0, 1'b1);
    do_addr(6'd30, 32'h90);
    ld_query(32'h80, 1'b0, 1'b0, 32'd0, 1'b0);
    ld_query(32'h90, 1'b1, 1'b0, 32'h30, 1'b1);
    do_flush();

    // Youngest match without data stalls until the CDB fills it
    do_alloc(6'd31, 6'h20, 32'd7, '0, 1'b1);
    do_alloc(6'd32, 6'h20, 32'd0, 6'd40, 1'b0);
    do_addr(6'd31, 32'h50);
    do_addr(6'd32, 32'h50);
    ld_query(32'h50, 1'b0, 1'b1, 32'd0, 1'b1);
    do_cdb(6'd40, 32'h99);
    ld_query(32'h50, 1'b1, 1'b0, 32'h99, 1'b1);
    do_flush();
    check("flush_uncommitted_count", 64'(count), 64'd0);

    // Flush keeps committed entries, including one committed in the flush cycle
    for (int i = 1; i <= 4; i++) do_alloc(IW'(i), 6'h22, DW'(8'h11 * i), '0, 1'b1);
    for (int i = 1; i <= 4; i++) do_addr(IW'(i), DW'(32'h1000 + 4 * i));
    do_commit(6'd1, 1'b0);
    commit_valid = 1'b1; commit_id = 6'd2; commit_invalidate = 1'b1;
    do_flush();
    commit_valid = 1'b0; commit_invalidate = 1'b0;
    check("flush_survivors", 64'(count), 64'd2);
    check("survivor_mem_valid", 64'(mem_valid), 64'd1);
    drain_one(6'h22, 6'd1, 32'h1004, 32'h11);
    check("squashed_count", 64'(count), 64'd1);
    check("squashed_mem_valid", 64'(mem_valid), 64'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("squashed_popped", 64'(count), 64'd0);
    check("squashed_empty", 64'(empty), 64'd1);

    // Alloc captures same-cycle CDB data
    cdb_valid = 1'b1; cdb = {6'd51, 32'hCAFE};
    do_alloc(6'd50, 6'h23, 32'h0, 6'd51, 1'b0);
    cdb_valid = 1'b0;
    do_addr(6'd50, 32'h300);
    ld_query(32'h300, 1'b1, 1'b0, 32'hCAFE, 1'b1);
    do_commit(6'd50, 1'b0);
    check("bypass_mem_valid", 64'(mem_valid), 64'd1);
    drain_one(6'h23, 6'd50, 32'h300, 32'hCAFE);

    // Reset mid-operation discards committed entries too
    do_alloc(6'd60, 6'h20, 32'h1, '0, 1'b1);
    do_alloc(6'd61, 6'h20, 32'h2, '0, 1'b1);
    do_commit(6'd60, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_empty", 64'(empty), 64'd1);
    check("midrst_mem_valid", 64'(mem_valid), 64'd0);

    tick();
    check("mem_q_drained", 64'(mem_q.size()), 64'd0);
    check("ld_q_drained", 64'(ld_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
